shift_operator_l_seq: RTL and testbench



---
 rtl/shift_pkg.sv | 6 +
 rtl/shift_operator_l_seq.sv | 48 ++++
 tb/tb_shift_operator_l_seq.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/shift_pkg.sv
// shift_pkg: state encoding and default sizing for the multi-cycle left shifter
package shift_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2} state_t;
    localparam int WIDTH_D = 5;
    localparam int SHW_D = 2;
endpackage

// File: rtl/shift_operator_l_seq.sv
// shift_operator_l_seq: one-bit-per-clock logical left shifter with start/ready/done handshake
module shift_operator_l_seq
    import shift_pkg::*;
#(
    parameter int WIDTH = WIDTH_D,
    parameter int SHW = SHW_D
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [SHW-1:0]   bshift,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] y,
    output logic             carry_out
);
    state_t state, next;
    logic [SHW-1:0] cnt;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            y <= '0;
            carry_out <= 1'b0;
            cnt <= '0;
        end else begin
            state <= next;
            if (state == IDLE && start) begin
                y <= A;
                cnt <= bshift;
                carry_out <= 1'b0;
            end else if (state == SHIFT) begin
                carry_out <= y[WIDTH-1];
                y <= {y[WIDTH-2:0], 1'b0};
                cnt <= cnt - 1'b1;
            end
        end
    end
    always_comb begin
        next = state;
        next = (state == IDLE) ? (start ? ((bshift != '0) ? SHIFT : DONE) : IDLE) :
               (state == SHIFT) ? ((cnt == SHW'(1)) ? DONE : SHIFT) : IDLE;
    end
    assign ready = (state == IDLE);
    assign busy = (state == SHIFT);
    assign done = (state == DONE);
endmodule

// File: tb/tb_shift_operator_l_seq.sv
// tb_shift_operator_l_seq: vector table, handshake corner cases and random ops vs. an arithmetic model
module tb_shift_operator_l_seq;
    localparam int W = 5;
    localparam int S = 2;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic [W-1:0] A = '0;
    logic [S-1:0] bshift = '0;
    logic ready, busy, done, carry_out;
    logic [W-1:0] y;
    int checks = 0;
    int errors = 0;

    shift_operator_l_seq #(.WIDTH(W), .SHW(S)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .A(A), .bshift(bshift),
        .ready(ready), .busy(busy), .done(done), .y(y), .carry_out(carry_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [S-1:0] b;
        logic [W-1:0] ey;
        logic ec;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, got, exp);
        end
    endtask

    // Reference: the last bit pushed past the MSB lands at bit WIDTH of the widened product.
    function automatic void model(input logic [W-1:0] a, input logic [S-1:0] b,
                                  output logic [W-1:0] ey, output logic ec);
        logic [W+15:0] w;
        w = {{16{1'b0}}, a} << b;
        ey = w[W-1:0];
        ec = (b == 0) ? 1'b0 : w[W];
    endfunction

    task automatic wait_ready();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (ready) return;
        end
        chk("ready_timeout", 0, 1);
    endtask

    task automatic run_op(input string name, input logic [W-1:0] a, input logic [S-1:0] b,
                          input logic [W-1:0] ey, input logic ec);
        int lat, bcnt;
        wait_ready();
        A = a;
        bshift = b;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        lat = 0;
        bcnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            lat++;
            if (busy) bcnt++;
            if (done) break;
        end
        chk({name, "_latency"}, lat, b + 1);
        chk({name, "_busy_cycles"}, bcnt, b);
        chk({name, "_y"}, y, ey);
        chk({name, "_carry"}, carry_out, ec);
        @(negedge clk);
        chk({name, "_done_pulse"}, {done, ready}, 2'b01);
        chk({name, "_hold_y"}, y, ey);
    endtask

    initial begin
        vec_t v[6];
        logic [W-1:0] ry;
        logic rc;
        int ndone;
        v[0] = '{5'b10111, 2'd2, 5'b11100, 1'b0};
        v[1] = '{5'b10111, 2'd3, 5'b11000, 1'b1};
        v[2] = '{5'b01011, 2'd0, 5'b01011, 1'b0};
        v[3] = '{5'b11111, 2'd1, 5'b11110, 1'b1};
        v[4] = '{5'b00001, 2'd3, 5'b01000, 1'b0};
        v[5] = '{5'b01000, 2'd2, 5'b00000, 1'b1};

        #12;
        chk("reset_flags", {ready, busy, done}, 3'b100);
        chk("reset_y", y, 0);
        chk("reset_carry", carry_out, 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) run_op($sformatf("vec%0d", i), v[i].a, v[i].b, v[i].ey, v[i].ec);

        // start during SHIFT must be ignored
        wait_ready();
        A = 5'b10111; bshift = 2'd2; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        A = 5'b11111; bshift = 2'd1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        chk("ign_done", done, 1);
        chk("ign_y", y, 5'b11100);
        @(negedge clk);
        chk("ign_idle", {ready, busy, done}, 3'b100);
        @(negedge clk);
        chk("ign_not_queued", {ready, y}, {1'b1, 5'b11100});

        // back-to-back with start held high
        wait_ready();
        A = 5'b00001; bshift = 2'd1; start = 1'b1;
        @(posedge clk);
        ndone = 0;
        for (int n = 1; n <= 6; n++) begin
            @(negedge clk);
            if (n == 1) A = 5'b10000;
            if (done) ndone++;
            if (n == 2) begin
                chk("b2b_done1", done, 1);
                chk("b2b_y1", {carry_out, y}, {1'b0, 5'b00010});
            end
            if (n == 5) begin
                chk("b2b_done2", done, 1);
                chk("b2b_y2", {carry_out, y}, {1'b1, 5'b00000});
                start = 1'b0;
            end
        end
        chk("b2b_pulses", ndone, 2);

        // asynchronous reset mid-SHIFT
        wait_ready();
        A = 5'b10111; bshift = 2'd3; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_mid_busy", busy, 1);
        #1 rst_n = 1'b0;
        #1;
        chk("rst_mid_flags", {ready, busy, done}, 3'b100);
        chk("rst_mid_y", {carry_out, y}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        chk("rst_no_done", ndone, 0);

        for (int i = 0; i < 40; i++) begin
            logic [W-1:0] ra;
            logic [S-1:0] rb;
            ra = W'($urandom);
            rb = S'($urandom);
            model(ra, rb, ry, rc);
            run_op($sformatf("rnd%0d", i), ra, rb, ry, rc);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
